// File: rtl/inst_loader.sv
// Instruction-memory loader: pairs a 16-bit word stream into 32-bit instructions,
// writes them into a DEPTH-entry memory and serves registered fetches to the core.
module inst_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [15:0]       load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              busy,
  output logic [ADDR_W:0]   instr_count,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_inst
);

  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t            state, state_next;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   ptr_inc;
  logic [15:0]       hi_reg, lo_reg;
  logic [31:0]       mem [DEPTH];
  logic              len_ok;
  logic              start_ok;
  logic              last_write;

  assign len_ok     = (load_len != '0) && (load_len <= DEPTH_L);
  assign start_ok   = (state == IDLE) && load_start && len_ok;
  assign ptr_inc    = {1'b0, wr_ptr} + ONE_L;
  assign last_write = (ptr_inc == len_q);

  assign load_ready = (state == LOAD_HI) || (state == LOAD_LO);
  assign load_done  = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD_HI;
      LOAD_HI: if (load_valid) state_next = LOAD_LO;
      LOAD_LO: if (load_valid) state_next = WRITE;
      WRITE:   state_next = last_write ? DONE : LOAD_HI;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory is flop-based so reset can wipe any partial load in one step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q       <= '0;
      wr_ptr      <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      instr_count <= '0;
      load_err    <= 1'b0;
      fetch_inst  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      load_err   <= (state == IDLE) && load_start && !len_ok;
      fetch_inst <= mem[fetch_addr];
      case (state)
        IDLE: if (start_ok) begin
          len_q       <= load_len;
          wr_ptr      <= '0;
          instr_count <= '0;
        end
        LOAD_HI: if (load_valid) hi_reg <= load_data;
        LOAD_LO: if (load_valid) lo_reg <= load_data;
        WRITE: begin
          mem[wr_ptr] <= {hi_reg, lo_reg};
          instr_count <= ptr_inc;
          if (!last_write) wr_ptr <= ptr_inc[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected fetch data, done counts and error
// pulses are queued at stimulus time and checked by a free-running monitor.
module tb_inst_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              load_valid = 1'b0;
  logic [15:0]       load_data = '0;
  logic              load_ready;
  logic              load_done;
  logic              load_err;
  logic              busy;
  logic [ADDR_W:0]   instr_count;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [31:0]       fetch_inst;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] fetchQ [$];
  int          doneQ [$];
  int          errPending = 0;
  logic        fetchReq = 1'b0;
  logic        fetchValidD = 1'b0;
  logic [15:0] stream [$];

  inst_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .load_err(load_err), .busy(busy),
    .instr_count(instr_count), .fetch_addr(fetch_addr), .fetch_inst(fetch_inst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) fetchValidD <= fetchReq;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (fetchValidD) begin
      if (fetchQ.size() == 0) checkOutput("fetch_unexpected", 32'd1, 32'd0);
      else checkOutput("fetch_data", fetch_inst, fetchQ.pop_front());
    end
    if (load_done === 1'b1) begin
      if (doneQ.size() == 0) checkOutput("done_unexpected", 32'd1, 32'd0);
      else checkOutput("done_count", 32'(instr_count), 32'(doneQ.pop_front()));
    end
    if (load_err === 1'b1) begin
      if (errPending == 0) checkOutput("err_unexpected", 32'd1, 32'd0);
      else begin
        errPending--;
        checkOutput("err_pulse", 32'd1, 32'd1);
      end
    end
  end

  task automatic doFetch(input int addr, input logic [31:0] expected);
    @(posedge clk); #1;
    fetch_addr = ADDR_W'(addr);
    fetchReq   = 1'b1;
    fetchQ.push_back(expected);
    @(posedge clk); #1;
    fetchReq = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] word, input int gap);
    bit accepted = 0;
    load_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    load_valid = 1'b1;
    load_data  = word;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (load_ready) begin
        @(posedge clk); #1;
        accepted = 1;
      end
    end
    load_valid = 1'b0;
    if (!accepted) checkOutput("word_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    checkOutput("idle_reached", 32'(idle), 32'd1);
  endtask

  task automatic issueStart(input int len);
    @(posedge clk); #1;
    load_start = 1'b1;
    load_len   = (ADDR_W+1)'(len);
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic runLoad(input int len, input int gap);
    issueStart(len);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("ready_after_start", 32'(load_ready), 32'd1);
    while (stream.size() > 0) applyStimulus(stream.pop_front(), gap);
    doneQ.push_back(len);
    waitIdle();
    checkOutput("done_seen", 32'(doneQ.size()), 32'd0);
    checkOutput("instr_count", 32'(instr_count), 32'(len));
  endtask

  task automatic illegalStart(input int len);
    errPending++;
    issueStart(len);
    checkOutput("err_busy_low", 32'(busy), 32'd0);
    checkOutput("err_level", 32'(load_err), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("err_consumed", 32'(errPending), 32'd0);
    checkOutput("err_busy_still_low", 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(load_ready), 32'd0);
    checkOutput("rst_done", 32'(load_done), 32'd0);
    checkOutput("rst_err", 32'(load_err), 32'd0);
    checkOutput("rst_count", 32'(instr_count), 32'd0);
    checkOutput("rst_fetch", fetch_inst, 32'd0);
    #6;
    reset = 1'b0;
  endtask

  task automatic pushBasicStream();
    stream = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0001, 16'h0002};
  endtask

  task automatic checkBasicMem();
    doFetch(0, 32'h12345678);
    doFetch(1, 32'h9ABCDEF0);
    doFetch(2, 32'h00010002);
    doFetch(3, 32'h00000000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    doReset();
    for (int a = 0; a < DEPTH; a++) doFetch(a, 32'h0);

    pushBasicStream();
    runLoad(3, 0);
    checkBasicMem();

    illegalStart(0);
    illegalStart(17);
    checkBasicMem();

    doReset();
    pushBasicStream();
    runLoad(3, 2);
    checkBasicMem();

    // second start arrives while the block waits in LOAD_LO
    issueStart(2);
    applyStimulus(16'hAAAA, 0);
    load_start = 1'b1;
    load_len   = 5'd1;
    @(posedge clk); #1;
    load_start = 1'b0;
    checkOutput("busy_ignore_start", 32'(busy), 32'd1);
    applyStimulus(16'hBBBB, 0);
    applyStimulus(16'hCCCC, 0);
    applyStimulus(16'hDDDD, 0);
    doneQ.push_back(2);
    waitIdle();
    checkOutput("busy_start_done", 32'(doneQ.size()), 32'd0);
    doFetch(0, 32'hAAAABBBB);
    doFetch(1, 32'hCCCCDDDD);
    doFetch(2, 32'h00010002);

    issueStart(16);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(16'h3000 + 16'(k), 0);
      applyStimulus(16'h4000 + 16'(k), 0);
    end
    @(posedge clk); #1;
    checkOutput("partial_count", 32'(instr_count), 32'd5);
    doReset();
    for (int a = 0; a < DEPTH; a++) doFetch(a, 32'h0);

    for (int k = 0; k < DEPTH; k++) begin
      stream.push_back(16'h1000 + 16'(k));
      stream.push_back(16'h2000 + 16'(k));
    end
    runLoad(16, 0);
    for (int a = 0; a < DEPTH; a++) doFetch(a, {16'h1000 + 16'(a), 16'h2000 + 16'(a)});

    repeat (3) @(posedge clk);
    checkOutput("fetchq_empty", 32'(fetchQ.size()), 32'd0);
    checkOutput("doneq_empty", 32'(doneQ.size()), 32'd0);
    checkOutput("err_none_left", 32'(errPending), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Instruction-memory loader and fetch port for the simple processor. It receives a 16-bit word stream over a valid/ready handshake and pairs the words into 32-bit instructions, high half first. It writes those instructions into a DEPTH-entry instruction memory and serves registered instruction fetches to the processor core. It holds the core idle while a load is in progress, replacing the core's preloaded program image with a runtime-loadable one.

## Interface
- DEPTH, 16, number of 32-bit instruction entries; power of two, ≥2
- ADDR_W, $clog2(DEPTH), fetch/write address width
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state, outputs and memory
- load_start  input  1  pulse; begins a load when block is idle
- load_len  input  ADDR_W+1  instruction count for this load, sampled with load_start; legal 1..DEPTH
- load_valid  input  1  load_data holds a valid word
- load_data  input  16  stream word
- load_ready  output  1  block accepts a word this cycle
- load_done  output  1  one-cycle pulse after the last instruction is written
- load_err  output  1  one-cycle pulse when load_start carries an illegal load_len
- busy  output  1  high in any state except IDLE; connect to the core's reset/hold
- instr_count  output  ADDR_W+1  instructions written by the last successful load, held
- fetch_addr  input  ADDR_W  core instruction address (PC)
- fetch_inst  output  32  mem[fetch_addr], registered

## Operation
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, DONE.
- IDLE with load_start=1:
  - If 1 ≤ load_len ≤ DEPTH: latch len, set wr_ptr=0, clear instr_count, go to LOAD_HI.
  - Otherwise (0 or > DEPTH): pulse load_err next cycle and stay in IDLE.
- load_start outside IDLE is ignored, with no error.
- load_ready=1 only in LOAD_HI and LOAD_LO.
- A word transfers on a rising edge with load_valid && load_ready.
- LOAD_HI: on transfer, hi_reg ← load_data, go to LOAD_LO. Otherwise stay.
- LOAD_LO: on transfer, lo_reg ← load_data, go to WRITE. Otherwise stay.
- WRITE:
  - mem[wr_ptr] ← {hi_reg, lo_reg}, instr_count ← wr_ptr+1.
  - If wr_ptr+1 == len, go to DONE. Otherwise wr_ptr ← wr_ptr+1 and go to LOAD_HI.
  - wr_ptr never wraps; len ≤ DEPTH guarantees this.
- DONE: load_done=1 for exactly this cycle, then IDLE.
- Entries at or above len keep their prior contents. They are zero after reset.
- Fetch:
  - fetch_inst ← mem[fetch_addr] every cycle, regardless of state.
  - Read during a write to the same address returns the old data.
- Reset asserted mid-load:
  - Immediately returns to IDLE; busy and load_ready drop at once.
  - Memory and instr_count clear to 0.
  - A partial load leaves no trace.

## Timing
- Reset values: load_ready=0, load_done=0, load_err=0, busy=0, instr_count=0, fetch_inst=0, all mem entries 0, state IDLE.
- load_start sampled at edge N:
  - Legal len: busy=1 and load_ready=1 from N+1.
  - Illegal len: load_err=1 during N+1 only.
- Minimum 3 cycles per instruction (HI, LO, WRITE); load_ready=0 during WRITE.
- Minimum total load time: 3·len + 1 cycles from the first LOAD_HI cycle to the return to IDLE.
- load_done and the final instr_count update are visible the cycle after the last WRITE. busy falls the cycle after load_done.
- fetch_inst has 1-cycle latency: address at edge N, data valid after edge N+1.
- A fetch issued after busy falls returns the newly loaded data.
- load_valid may toggle freely; idle cycles in the stream only extend LOAD_HI/LOAD_LO.

## Test plan
- Reset: assert reset mid-cycle (asynchronous), then release.
  - All outputs 0 immediately.
  - Fetch of addr 0..15 returns 32'h0.
- Basic load: load_len=3, continuous valid, words 1234,5678,9ABC,DEF0,0001,0002.
  - load_done pulses once; instr_count=3.
  - Fetch 0/1/2 returns 12345678, 9ABCDEF0, 00010002; fetch 3 returns 0.
- Backpressure/gaps: same stream with load_valid low for 2 cycles between every word.
  - Identical memory contents.
  - No word is accepted while load_ready=0 in WRITE.
- Illegal length: load_len=0, then load_len=17.
  - load_err pulses once per attempt; busy stays 0; memory unchanged.
- Start while busy: a second load_start during LOAD_LO is ignored.
  - The load completes with the original len; no load_err.
- Reset mid-load: load_len=16, reset after the 5th instruction write.
  - busy=0 at once; instr_count=0; all entries 0.
  - A subsequent full 16-entry load fills addr 0..15; instr_count=16.
